// File: rtl/ahb_mem_ctrl_if.sv
// ahb_mem_ctrl_if: AHB-Lite slave bus plus word-memory port bundle.
// The slave modport is the controller's view; master is the environment's view.
interface ahb_mem_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] mem_read_addr;
  logic        mem_read_flag;
  logic [31:0] mem_rdata;
  logic [31:0] mem_write_addr;
  logic        mem_write_flag;
  logic [31:0] mem_wdata;

  modport slave (
    input  HSEL,
    input  HADDR,
    input  HTRANS,
    input  HWRITE,
    input  HSIZE,
    input  HREADY,
    input  HWDATA,
    output HRDATA,
    output HREADYOUT,
    output HRESP,
    output mem_read_addr,
    output mem_read_flag,
    input  mem_rdata,
    output mem_write_addr,
    output mem_write_flag,
    output mem_wdata
  );

  modport master (
    output HSEL,
    output HADDR,
    output HTRANS,
    output HWRITE,
    output HSIZE,
    output HREADY,
    output HWDATA,
    input  HRDATA,
    input  HREADYOUT,
    input  HRESP,
    input  mem_read_addr,
    input  mem_read_flag,
    output mem_rdata,
    input  mem_write_addr,
    input  mem_write_flag,
    input  mem_wdata
  );
endinterface

// File: rtl/ahb_mem_ctrl.sv
// ahb_mem_ctrl: AHB-Lite slave driving a word-addressed memory with wait states.
// Define MEM_CTRL_ERR_EN to return ERROR for bad size, alignment or range.
module ahb_mem_ctrl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic           HCLK,
  input logic           HRESETn,
  ahb_mem_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [2:0] WS_LOAD =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] idx_q, idx_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;

  logic        accept_w;
  logic [31:0] off_w;
  logic [31:0] idx_w;
  logic        bad_w;

  logic        rdy_w;
  logic        resp_w;
  logic        rdf_w;
  logic        wrf_w;
  logic [31:0] rdata_w;

  assign accept_w = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign off_w    = bus.HADDR - BASE_ADDR;

`ifdef MEM_CTRL_ERR_EN
  localparam logic ERR_RESP = 1'b1;

  assign idx_w = {2'b00, off_w[31:2]};
  assign bad_w = (bus.HSIZE != 3'b010)
               | (off_w[1:0] != 2'b00)
               | (idx_w >= 32'(MEM_WORDS));
`else
  localparam logic ERR_RESP = 1'b0;

  logic unused_w;

  // Index wraps modulo the memory depth; size and byte lane are ignored.
  assign idx_w    = 32'(off_w[AW+1:2]);
  assign bad_w    = 1'b0;
  assign unused_w = ^{off_w[31:AW+2], off_w[1:0], bus.HSIZE};
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= 32'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        // IDLE, ACCESS and ERR2 all present HREADYOUT=1 and may accept.
        state_d = S_IDLE;
        if (accept_w) begin
          idx_d = idx_w;
          wr_d  = bus.HWRITE;
          err_d = bad_w;
          if (bad_w) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
    endcase
  end

  always_comb begin
    rdy_w   = 1'b1;
    resp_w  = 1'b0;
    rdf_w   = 1'b0;
    wrf_w   = 1'b0;
    rdata_w = 32'd0;
    unique case (1'b1)
      (state_q == S_WAIT): begin
        rdy_w = 1'b0;
      end
      (state_q == S_ACCESS): begin
        rdf_w = ~wr_q & ~err_q;
        wrf_w = wr_q & ~err_q;
        if (rdf_w) begin
          rdata_w = bus.mem_rdata;
        end
      end
      (state_q == S_ERR1): begin
        rdy_w  = 1'b0;
        resp_w = ERR_RESP;
      end
      (state_q == S_ERR2): begin
        resp_w = ERR_RESP;
      end
      default: begin
      end
    endcase
  end

  assign bus.HREADYOUT      = rdy_w;
  assign bus.HRESP          = resp_w;
  assign bus.HRDATA         = rdata_w;
  assign bus.mem_read_flag  = rdf_w;
  assign bus.mem_write_flag = wrf_w;
  assign bus.mem_read_addr  = idx_q;
  assign bus.mem_write_addr = idx_q;
  assign bus.mem_wdata      = bus.HWDATA;

endmodule

// File: tb/tb_ahb_mem_ctrl.sv
// tb_ahb_mem_ctrl: two controllers (0 and 3 wait states) on private memories,
// checked every cycle against a transfer-schedule model plus literal checks.
module tb_ahb_mem_ctrl;

  localparam int MW      = 4096;
  localparam int K_NONE  = -1;
  localparam int K_STALL = 0;
  localparam int K_RD    = 1;
  localparam int K_WR    = 2;
  localparam int K_E1    = 3;
  localparam int K_E2    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        hsel[2];
  logic [31:0] haddr[2];
  logic [1:0]  htrans[2];
  logic        hwrite[2];
  logic [2:0]  hsize[2];
  logic [31:0] hwdata[2];

  logic        ordy[2];
  logic        oresp[2];
  logic        ordf[2];
  logic        owrf[2];
  logic [31:0] ordata[2];
  logic [31:0] orad[2];
  logic [31:0] owad[2];
  logic [31:0] owdat[2];

  bit [31:0] memE0[MW];
  bit [31:0] memE1[MW];
  bit [31:0] memM[2][MW];

  int        qk[2][16];
  bit [31:0] qi[2][16];
  int        qn[2];
  bit [31:0] last_idx[2];
  bit        rdy_prev[2];

  int vec  = 0;
  int errs = 0;

  ahb_mem_ctrl_if b0();
  ahb_mem_ctrl_if b1();

  ahb_mem_ctrl #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(b0.slave)
  );
  ahb_mem_ctrl #(.WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESETn(rst_n), .bus(b1.slave)
  );

  assign b0.HSEL      = hsel[0];
  assign b0.HADDR     = haddr[0];
  assign b0.HTRANS    = htrans[0];
  assign b0.HWRITE    = hwrite[0];
  assign b0.HSIZE     = hsize[0];
  assign b0.HWDATA    = hwdata[0];
  assign b0.HREADY    = b0.HREADYOUT;
  assign b0.mem_rdata = memE0[b0.mem_read_addr[11:0]];

  assign b1.HSEL      = hsel[1];
  assign b1.HADDR     = haddr[1];
  assign b1.HTRANS    = htrans[1];
  assign b1.HWRITE    = hwrite[1];
  assign b1.HSIZE     = hsize[1];
  assign b1.HWDATA    = hwdata[1];
  assign b1.HREADY    = b1.HREADYOUT;
  assign b1.mem_rdata = memE1[b1.mem_read_addr[11:0]];

  assign ordy[0]   = b0.HREADYOUT;
  assign oresp[0]  = b0.HRESP;
  assign ordf[0]   = b0.mem_read_flag;
  assign owrf[0]   = b0.mem_write_flag;
  assign ordata[0] = b0.HRDATA;
  assign orad[0]   = b0.mem_read_addr;
  assign owad[0]   = b0.mem_write_addr;
  assign owdat[0]  = b0.mem_wdata;
  assign ordy[1]   = b1.HREADYOUT;
  assign oresp[1]  = b1.HRESP;
  assign ordf[1]   = b1.mem_read_flag;
  assign owrf[1]   = b1.mem_write_flag;
  assign ordata[1] = b1.HRDATA;
  assign orad[1]   = b1.mem_read_addr;
  assign owad[1]   = b1.mem_write_addr;
  assign owdat[1]  = b1.mem_wdata;

  always @(posedge clk) begin
    if (b0.mem_write_flag) memE0[b0.mem_write_addr[11:0]] <= b0.mem_wdata;
    if (b1.mem_write_flag) memE1[b1.mem_write_addr[11:0]] <= b1.mem_wdata;
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit [31:0] map_idx(input logic [31:0] a);
`ifdef MEM_CTRL_ERR_EN
    return {2'b00, a[31:2]};
`else
    return {2'b00, a[31:2]} % MW;
`endif
  endfunction

  function automatic bit is_bad(input logic [31:0] a, input logic [2:0] sz);
    bit b;
    b = 1'b0;
`ifdef MEM_CTRL_ERR_EN
    b = (sz != 3'b010) || (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= MW);
`endif
    return b;
  endfunction

  task automatic push(input int k, input int kd, input bit [31:0] ix);
    qk[k][qn[k]] = kd;
    qi[k][qn[k]] = ix;
    qn[k] = qn[k] + 1;
  endtask

  task automatic model_edge(input int k);
    bit rdy;
    bit acc;
    bit [31:0] ix;
    rdy = (qn[k] == 0) || !(qk[k][0] == K_STALL || qk[k][0] == K_E1);
    acc = hsel[k] && htrans[k][1] && rdy;
    if (qn[k] > 0) begin
      if (qk[k][0] == K_WR) memM[k][qi[k][0][11:0]] = hwdata[k];
      for (int j = 0; j < 15; j++) begin
        qk[k][j] = qk[k][j+1];
        qi[k][j] = qi[k][j+1];
      end
      qn[k] = qn[k] - 1;
    end
    if (acc) begin
      ix = map_idx(haddr[k]);
      last_idx[k] = ix;
      if (is_bad(haddr[k], hsize[k])) begin
        push(k, K_E1, ix);
        push(k, K_E2, ix);
      end else begin
        for (int w = 0; w < ws_of(k); w++) push(k, K_STALL, ix);
        push(k, hwrite[k] ? K_WR : K_RD, ix);
      end
    end
  endtask

  task automatic cmp(input int k);
    int kd;
    bit er, ep, erd, ewr;
    bit [31:0] ed, ea;
    kd  = (qn[k] > 0) ? qk[k][0] : K_NONE;
    er  = !(kd == K_STALL || kd == K_E1);
    ep  = (kd == K_E1 || kd == K_E2);
    erd = (kd == K_RD);
    ewr = (kd == K_WR);
    ed  = erd ? memM[k][qi[k][0][11:0]] : 32'h0;
    ea  = last_idx[k];
    vec = vec + 1;
    if (ordy[k] !== er || oresp[k] !== ep || ordf[k] !== erd ||
        owrf[k] !== ewr || ordata[k] !== ed || orad[k] !== ea ||
        owad[k] !== ea || owdat[k] !== hwdata[k]) begin
      errs = errs + 1;
      $display("FAIL cycle u%0d t=%0t: got rdy%b resp%b rd%b wr%b data %h ra %h wa %h wd %h, want rdy%b resp%b rd%b wr%b data %h addr %h wd %h",
               k, $time, ordy[k], oresp[k], ordf[k], owrf[k], ordata[k],
               orad[k], owad[k], owdat[k], er, ep, erd, ewr, ed, ea, hwdata[k]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        qn[0] = 0;
        qn[1] = 0;
        last_idx[0] = 32'd0;
        last_idx[1] = 32'd0;
      end else begin
        model_edge(0);
        model_edge(1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      rdy_prev[0] = ordy[0];
      rdy_prev[1] = ordy[1];
      cmp(0);
      cmp(1);
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    vec = vec + 1;
    if (got !== want) begin
      errs = errs + 1;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic xfer(input int k, input bit wr, input logic [31:0] a,
                      input logic [31:0] d);
    bit ok;
    hsel[k]   = 1'b1;
    htrans[k] = 2'b10;
    hwrite[k] = wr;
    haddr[k]  = a;
    hsize[k]  = 3'b010;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk);
      ok = rdy_prev[k];
    end
    #1;
    vec = vec + 1;
    if (!ok) begin
      errs = errs + 1;
      $display("FAIL accept u%0d addr %h: got no accept want accept", k, a);
    end
    hsel[k]   = 1'b0;
    htrans[k] = 2'b00;
    if (wr) hwdata[k] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_low(input int k, output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ordy[k]) break;
      n = n + 1;
    end
  endtask

  int n;

  initial begin
    for (int k = 0; k < 2; k++) begin
      hsel[k]   = 1'b0;
      haddr[k]  = 32'h0;
      htrans[k] = 2'b00;
      hwrite[k] = 1'b0;
      hsize[k]  = 3'b010;
      hwdata[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_rdy", ordy[k], 1);
      check("rst_resp_flags", {oresp[k], ordf[k], owrf[k]}, 0);
      check("rst_rdata", ordata[k], 0);
      check("rst_addr", orad[k] | owad[k], 0);
    end
    rst_n = 1'b1;
    idle(1);

    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_flag", owrf[0], 1);
    check("wr_addr", owad[0], 32'd4);
    check("wr_rdy", ordy[0], 1);
    xfer(0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("wr_flag_once", owrf[0], 0);
    check("rd_data", ordata[0], 32'hDEADBEEF);
    check("rd_rdy", ordy[0], 1);
    idle(2);

    xfer(1, 1'b0, 32'h0, 32'h0);
    count_low(1, n);
    check("ws3_low_cycles", n, 3);
    check("ws3_rd_flag", ordf[1], 1);
    idle(2);

    xfer(0, 1'b1, 32'h8, 32'h1234_5678);
    xfer(0, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    check("pipe0_rd", ordata[0], 32'h1234_5678);
    idle(2);
    xfer(1, 1'b1, 32'h8, 32'h1234_5678);
    xfer(1, 1'b0, 32'h8, 32'h0);
    count_low(1, n);
    check("pipe3_low_cycles", n, 3);
    check("pipe3_rd", ordata[1], 32'h1234_5678);
    idle(2);

    xfer(0, 1'b1, 32'h0, 32'hCAFE_F00D);
    idle(1);
    xfer(0, 1'b0, 32'h4000, 32'h0);
    @(negedge clk);
`ifdef MEM_CTRL_ERR_EN
    check("err_first", {ordy[0], oresp[0]}, 2'b01);
    check("err_strobes", {ordf[0], owrf[0]}, 0);
    check("err_rdata", ordata[0], 0);
    @(negedge clk);
    check("err_second", {ordy[0], oresp[0]}, 2'b11);
`else
    check("wrap_addr", orad[0], 0);
    check("wrap_rd_flag", ordf[0], 1);
    check("wrap_rdata", ordata[0], 32'hCAFE_F00D);
`endif
    idle(2);
    xfer(1, 1'b0, 32'h2, 32'h0);
    @(negedge clk);
`ifdef MEM_CTRL_ERR_EN
    check("mis_first", {ordy[1], oresp[1], ordf[1]}, 3'b010);
    @(negedge clk);
    check("mis_second", {ordy[1], oresp[1], ordf[1]}, 3'b110);
    check("mis_rdata", ordata[1], 0);
`else
    check("mis_stall", {ordy[1], oresp[1]}, 2'b00);
`endif
    idle(5);

    hsel[0] = 1'b1; htrans[0] = 2'b01; haddr[0] = 32'h10;
    @(posedge clk);
    @(negedge clk);
    check("busy_resp", {ordy[0], oresp[0], ordf[0], owrf[0]}, 4'b1000);
    hsel[0] = 1'b0; htrans[0] = 2'b10;
    @(posedge clk);
    @(negedge clk);
    check("nosel_resp", {ordy[0], oresp[0], ordf[0], owrf[0]}, 4'b1000);
    htrans[0] = 2'b00;
    idle(1);

    xfer(1, 1'b1, 32'h20, 32'h55AA_55AA);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_abort_rdy", {ordy[1], oresp[1], ordf[1], owrf[1]}, 4'b1000);
    check("rst_abort_addr", orad[1] | owad[1] | ordata[1], 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mem_kept", memE1[8], 0);
    idle(1);
    xfer(1, 1'b1, 32'h20, 32'h0BAD_CAFE);
    xfer(1, 1'b0, 32'h20, 32'h0);
    count_low(1, n);
    check("post_rst_rd", ordata[1], 32'h0BAD_CAFE);
    check("post_rst_mem", memE1[8], 32'h0BAD_CAFE);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
